// File: rtl/fmap_pkg.sv
// Shared types and width helpers for the feature-map double buffer.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package fmap_pkg;

  // Lifecycle of one frame slot.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } slot_state_t;

  // Bits needed to index n items; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Address width for a bank holding 'depth' words.
  function automatic int addr_width(input int depth);
    return cnt_width(depth);
  endfunction

  // Width of the channel (kernel index) counter.
  function automatic int chan_width(input int kernels);
    return cnt_width(kernels);
  endfunction

  // Width of the pixel counter for a square image of side 'side'.
  function automatic int pix_width(input int side);
    return cnt_width(side * side);
  endfunction

endpackage

// File: rtl/fmap_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// Latency: read data appears one cycle after re_i; rdata_o holds while re_i is low.
// Backpressure: none; the caller decides when to read or write.
module fmap_bank #(
  parameter int Width     = 16,
  parameter int Depth     = 16,
  parameter int AddrWidth = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port; the register holds its value until the next read.
  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fmap_buffer.sv
// Two-slot feature-map store: PE-lane kernel-group writes in, channel-major raster replay out.
// Latency: first out_valid two cycles after the final beat of a frame; 1 pixel/cycle sustained.
// Backpressure: in_ready low while the write slot is FULL/DRAINING; output held stable under !out_ready.
module fmap_buffer
  import fmap_pkg::*;
#(
  parameter int NumberOfK          = 4,
  parameter int BitSize            = 16,
  parameter int ProcessingElements = 2,
  parameter int ImageWidth         = 4
) (
  input  logic                                  clk,
  input  logic                                  res,
  input  logic [NumberOfK-1:0]                  in_valid,
  input  logic [ProcessingElements*BitSize-1:0] in_data,
  output logic                                  in_ready,
  output logic [BitSize-1:0]                    out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [chan_width(NumberOfK)-1:0]      out_channel,
  output logic                                  out_last,
  output logic                                  frame_done,
  output logic                                  err
);

  localparam int K     = NumberOfK;
  localparam int PE    = ProcessingElements;
  localparam int G     = K / PE;
  localparam int TP    = ImageWidth * ImageWidth;
  localparam int Depth = 2 * G * TP;
  localparam int AW    = addr_width(Depth);
  localparam int CW    = chan_width(K);
  localparam int PW    = pix_width(ImageWidth);
  localparam int GW    = cnt_width(G);
  localparam int LW    = cnt_width(PE);

  slot_state_t slot_q [2];
  slot_state_t slot_d [2];

  logic          wr_ptr_q, wr_ptr_d, err_q, err_d;
  logic [GW-1:0] wr_grp_q, wr_grp_d;
  logic [PW-1:0] wr_pix_q, wr_pix_d;
  logic          rd_ptr_q, rd_ptr_d, rd_all_q, rd_all_d;
  logic [PW-1:0] rd_pix_q, rd_pix_d;
  logic [GW-1:0] rd_grp_q, rd_grp_d;
  logic [LW-1:0] rd_lane_q, rd_lane_d;
  logic [CW-1:0] rd_ch_q, rd_ch_d;

  // Output buffer: entry "r" is the RAM read register itself, entry "s" the older skid word.
  logic               rvld_q, rvld_d, r_last_q, r_last_d;
  logic [LW-1:0]      r_lane_q, r_lane_d;
  logic [CW-1:0]      r_ch_q, r_ch_d;
  logic               svld_q, svld_d, s_last_q, s_last_d;
  logic [BitSize-1:0] s_dat_q, s_dat_d;
  logic [CW-1:0]      s_ch_q, s_ch_d;
  logic               frame_done_q;

  logic [K-1:0]       exp_mask;
  logic               wr_beat, wr_good, wr_bad, wr_last;
  logic [AW-1:0]      wr_addr, rd_addr;
  slot_state_t        rd_state;
  logic               pop, can_issue, rd_issue, rd_last_pix, rd_final_pop;
  logic [BitSize-1:0] bank_rdata [PE];
  logic [BitSize-1:0] r_dat;

  // Write side: expected lane mask for the current group, beat qualification, bank address.
  always_comb begin
    exp_mask = '0;
    for (int k = 0; k < K; k++) exp_mask[k] = ((k / PE) == int'(wr_grp_q));
    in_ready = (slot_q[wr_ptr_q] == EMPTY) || (slot_q[wr_ptr_q] == FILLING);
    wr_beat  = (in_valid != '0) && in_ready;
    wr_good  = wr_beat && (in_valid == exp_mask);
    wr_bad   = wr_beat && !wr_good;
    wr_last  = wr_good && (wr_grp_q == GW'(G - 1)) && (wr_pix_q == PW'(TP - 1));
    wr_addr  = AW'(int'(wr_ptr_q) * G * TP + int'(wr_grp_q) * TP + int'(wr_pix_q));
  end

  // Write counters advance only on a well-formed beat; a malformed beat just raises err.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_grp_d = wr_grp_q;
    wr_pix_d = wr_pix_q;
    err_d    = err_q | wr_bad;
    if (wr_good) begin
      if (wr_grp_q == GW'(G - 1)) begin
        wr_grp_d = '0;
        if (wr_pix_q == PW'(TP - 1)) begin
          wr_pix_d = '0;
          wr_ptr_d = ~wr_ptr_q;
        end else begin
          wr_pix_d = wr_pix_q + PW'(1);
        end
      end else begin
        wr_grp_d = wr_grp_q + GW'(1);
      end
    end
  end

  // Read side: issue a RAM read only when the output buffer cannot overflow.
  always_comb begin
    rd_state     = slot_q[rd_ptr_q];
    pop          = out_valid && out_ready;
    can_issue    = !(svld_q && rvld_q && !pop);
    rd_issue     = ((rd_state == FULL) || ((rd_state == DRAINING) && !rd_all_q)) && can_issue;
    rd_last_pix  = (rd_pix_q == PW'(TP - 1));
    rd_addr      = AW'(int'(rd_ptr_q) * G * TP + int'(rd_grp_q) * TP + int'(rd_pix_q));
    rd_final_pop = pop && out_last && (out_channel == CW'(K - 1));
  end

  // Read counters walk channel-major; the pointer moves once the last pixel leaves.
  always_comb begin
    rd_pix_d  = rd_pix_q;
    rd_grp_d  = rd_grp_q;
    rd_lane_d = rd_lane_q;
    rd_ch_d   = rd_ch_q;
    rd_all_d  = rd_all_q;
    rd_ptr_d  = rd_ptr_q;
    if (rd_issue) begin
      if (rd_last_pix) begin
        rd_pix_d = '0;
        if (rd_ch_q == CW'(K - 1)) begin
          rd_ch_d   = '0;
          rd_lane_d = '0;
          rd_grp_d  = '0;
          rd_all_d  = 1'b1;
        end else begin
          rd_ch_d = rd_ch_q + CW'(1);
          if (rd_lane_q == LW'(PE - 1)) begin
            rd_lane_d = '0;
            rd_grp_d  = rd_grp_q + GW'(1);
          end else begin
            rd_lane_d = rd_lane_q + LW'(1);
          end
        end
      end else begin
        rd_pix_d = rd_pix_q + PW'(1);
      end
    end
    if (rd_final_pop) begin
      rd_all_d = 1'b0;
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Slot lifecycle; write and read transitions always target different slots.
  always_comb begin
    slot_d = slot_q;
    if (wr_good) slot_d[wr_ptr_q] = wr_last ? FULL : FILLING;
    if (rd_state == FULL) slot_d[rd_ptr_q] = DRAINING;
    if (rd_final_pop) slot_d[rd_ptr_q] = EMPTY;
  end

  // Output buffer: r is overwritten only after it is popped or moved into s.
  always_comb begin
    rvld_d   = rvld_q;
    r_lane_d = r_lane_q;
    r_ch_d   = r_ch_q;
    r_last_d = r_last_q;
    svld_d   = svld_q;
    s_dat_d  = s_dat_q;
    s_ch_d   = s_ch_q;
    s_last_d = s_last_q;
    if (rd_issue) begin
      rvld_d   = 1'b1;
      r_lane_d = rd_lane_q;
      r_ch_d   = rd_ch_q;
      r_last_d = rd_last_pix;
    end else if (pop && !svld_q) begin
      rvld_d = 1'b0;
    end
    if (rd_issue && rvld_q && !(pop && !svld_q)) begin
      svld_d   = 1'b1;
      s_dat_d  = r_dat;
      s_ch_d   = r_ch_q;
      s_last_d = r_last_q;
    end else if (svld_q && pop) begin
      svld_d = 1'b0;
    end
  end

  assign r_dat       = bank_rdata[r_lane_q];
  assign out_valid   = svld_q | rvld_q;
  assign out_data    = svld_q ? s_dat_q  : (rvld_q ? r_dat    : '0);
  assign out_channel = svld_q ? s_ch_q   : (rvld_q ? r_ch_q   : '0);
  assign out_last    = svld_q ? s_last_q : (rvld_q && r_last_q);
  assign frame_done  = frame_done_q;
  assign err         = err_q;

  // One bank per write lane; all banks read the same address and r_lane picks the word.
  for (genvar p = 0; p < PE; p++) begin : g_bank
    fmap_bank #(
      .Width     (BitSize),
      .Depth     (Depth),
      .AddrWidth (AW)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (wr_good),
      .waddr_i (wr_addr),
      .wdata_i (in_data[p*BitSize +: BitSize]),
      .re_i    (rd_issue),
      .raddr_i (rd_addr),
      .rdata_o (bank_rdata[p])
    );
  end

  // State registers; reset empties both slots and flushes the output buffer.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      slot_q[0]    <= EMPTY;
      slot_q[1]    <= EMPTY;
      wr_ptr_q     <= 1'b0;
      wr_grp_q     <= '0;
      wr_pix_q     <= '0;
      err_q        <= 1'b0;
      rd_ptr_q     <= 1'b0;
      rd_all_q     <= 1'b0;
      rd_pix_q     <= '0;
      rd_grp_q     <= '0;
      rd_lane_q    <= '0;
      rd_ch_q      <= '0;
      rvld_q       <= 1'b0;
      r_lane_q     <= '0;
      r_ch_q       <= '0;
      r_last_q     <= 1'b0;
      svld_q       <= 1'b0;
      s_dat_q      <= '0;
      s_ch_q       <= '0;
      s_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_grp_q     <= wr_grp_d;
      wr_pix_q     <= wr_pix_d;
      err_q        <= err_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_all_q     <= rd_all_d;
      rd_pix_q     <= rd_pix_d;
      rd_grp_q     <= rd_grp_d;
      rd_lane_q    <= rd_lane_d;
      rd_ch_q      <= rd_ch_d;
      rvld_q       <= rvld_d;
      r_lane_q     <= r_lane_d;
      r_ch_q       <= r_ch_d;
      r_last_q     <= r_last_d;
      svld_q       <= svld_d;
      s_dat_q      <= s_dat_d;
      s_ch_q       <= s_ch_d;
      s_last_q     <= s_last_d;
      frame_done_q <= rd_final_pop;
    end
  end

endmodule

// File: tb/tb_fmap_buffer.sv
// Directed bench for fmap_buffer with K=4, PE=2, 2x2 image, 8-bit pixels.
// Latency: checks the two-cycle first-output latency and one pixel per cycle drain.
// Backpressure: exercises held, random and blocked out_ready.
module tb_fmap_buffer;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_channel;
  logic        out_last;
  logic        frame_done;
  logic        err;

  typedef struct packed {
    logic [7:0] dat;
    logic [1:0] ch;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pops   = 0;
  logic rnd_rdy  = 1'b0;
  logic track_ir = 1'b0;
  logic ir_seen  = 1'b0;

  fmap_buffer #(
    .NumberOfK          (4),
    .BitSize            (8),
    .ProcessingElements (2),
    .ImageWidth         (2)
  ) dut (
    .clk         (clk),
    .res         (res),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_channel (out_channel),
    .out_last    (out_last),
    .frame_done  (frame_done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Pixel value for frame f, kernel k, pixel p: {f[1:0], k[1:0], 2'b00, p[1:0]}.
  function automatic logic [7:0] val(input int f, input int k, input int p);
    return 8'(f * 64 + k * 16 + p);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: score any output handshake, then check frame_done and stall stability.
  task automatic tick(output logic acc);
    logic       hs, fin, stall, pl;
    logic [7:0] pd;
    logic [1:0] pc;
    exp_t       e;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    acc = in_ready && (in_valid != 4'd0);
    hs  = out_valid && out_ready;
    fin = 1'b0;
    if (hs) begin
      pops++;
      chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.dat));
        chk("out_channel", 32'(out_channel), 32'(e.ch));
        chk("out_last", 32'(out_last), 32'(e.last));
        fin = e.last && (e.ch == 2'd3);
        if (track_ir && fin) chk("in_ready_low_at_final", 32'(in_ready), 32'd0);
      end
    end
    stall = out_valid && !out_ready;
    pd = out_data;
    pc = out_channel;
    pl = out_last;
    @(posedge clk);
    #1;
    cyc++;
    chk("frame_done", 32'(frame_done), 32'(fin));
    if (stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(pd));
      chk("stall_channel", 32'(out_channel), 32'(pc));
      chk("stall_last", 32'(out_last), 32'(pl));
    end
    if (track_ir && frame_done) begin
      ir_seen = 1'b1;
      chk("in_ready_up_at_frame_done", 32'(in_ready), 32'd1);
    end
  endtask

  // Queue the expected readback, then push the 8 beats of frame f.
  task automatic write_frame(input int f);
    logic acc;
    int   n;
    for (int k = 0; k < 4; k++)
      for (int p = 0; p < 4; p++)
        exp_q.push_back('{dat: val(f, k, p), ch: 2'(k), last: (p == 3)});
    for (int px = 0; px < 4; px++) begin
      for (int g = 0; g < 2; g++) begin
        in_valid = 4'(3 << (2 * g));
        in_data  = {val(f, 2 * g + 1, px), val(f, 2 * g, px)};
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
          tick(acc);
          n++;
        end
        chk("beat_accept", 32'(acc), 32'd1);
      end
    end
    in_valid = 4'd0;
    in_data  = 16'd0;
  endtask

  // Run until every queued pixel has been seen, then one extra cycle.
  task automatic drain(output int n);
    logic dummy;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick(dummy);
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    tick(dummy);
  endtask

  initial begin
    logic dummy;
    int   n, p0;
    res       = 1'b1;
    in_valid  = 4'd0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_channel", 32'(out_channel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    res = 1'b0;

    // Basic frame: latency, order, out_last, frame_done, full-rate drain.
    out_ready = 1'b1;
    write_frame(0);
    chk("latency_n1_idle", 32'(out_valid), 32'd0);
    tick(dummy);
    chk("latency_n2_valid", 32'(out_valid), 32'd1);
    chk("first_pixel", 32'(out_data), 32'h00);
    drain(n);
    chk("drain_cycles", 32'(n), 32'd16);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Two frames back to back with output blocked, third frame waits for a free slot.
    out_ready = 1'b0;
    write_frame(1);
    write_frame(2);
    chk("both_full_in_ready", 32'(in_ready), 32'd0);
    chk("blocked_valid", 32'(out_valid), 32'd1);
    chk("blocked_head", 32'(out_data), 32'(val(1, 0, 0)));
    in_valid = 4'b0011;
    in_data  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick(dummy);
      chk("blocked_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 4'd0;
    track_ir  = 1'b1;
    out_ready = 1'b1;
    write_frame(3);
    track_ir = 1'b0;
    chk("in_ready_rise_seen", 32'(ir_seen), 32'd1);
    drain(n);

    // Random backpressure during drain.
    rnd_rdy = 1'b1;
    write_frame(2);
    drain(n);
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;

    // Malformed beat: group 1 lanes while group 0 is expected.
    in_valid = 4'b1100;
    in_data  = 16'hdead;
    tick(dummy);
    in_valid = 4'd0;
    in_data  = 16'd0;
    chk("bad_beat_err", 32'(err), 32'd1);
    chk("bad_beat_no_output", 32'(out_valid), 32'd0);
    write_frame(3);
    drain(n);
    chk("err_sticky", 32'(err), 32'd1);

    // Reset while pixel 2 of a drain is on the output.
    write_frame(1);
    p0 = pops;
    n  = 0;
    while (pops - p0 < 2 && n < 100) begin
      tick(dummy);
      n++;
    end
    chk("pre_reset_pixel", 32'(out_data), 32'(val(1, 0, 2)));
    res = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_err", 32'(err), 32'd0);
    exp_q.delete();
    tick(dummy);
    res = 1'b0;
    tick(dummy);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    write_frame(2);
    drain(n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
